peripheral_wb_master_burst: RTL and testbench

- Synthesizable Wishbone B3 bus master sitting directly upstream of the bus slave models in the peripheral bench and of the GPIO Wishbone slave.
- Turns a simple command/write-data stream into single or incrementing-burst Wishbone cycles (cti/bte).
- Handles ack, err and rty terminations plus a bus timeout.
- Returns per-beat read data and a completion status on a response stream.

---
 rtl/peripheral_wb_master_burst.sv | 231 +++++++++++++++++++++++
 tb/tb_peripheral_wb_master_burst.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/peripheral_wb_master_burst.sv
// Wishbone B3 master: turns a command/write-data stream into single or incrementing bursts, one response per read beat.
// Bus cycle starts the cycle after cmd accept, responses follow termination by one cycle; rsp never stalls, missing wdat stalls stb.
module peripheral_wb_master_burst #(
    parameter int DW       = 32,
    parameter int AW       = 32,
    parameter int MAXBURST = 16,
    parameter int TIMEOUT  = 255,
    parameter int MAXRTY   = 3,
    localparam int LW      = $clog2(MAXBURST)
) (
    input  logic            wb_clk,
    input  logic            wb_rst,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic            cmd_we,
    input  logic [AW-1:0]   cmd_adr,
    input  logic [LW-1:0]   cmd_len,
    input  logic            wdat_valid,
    output logic            wdat_ready,
    input  logic [DW-1:0]   wdat,
    input  logic [DW/8-1:0] wsel,
    output logic            rsp_valid,
    output logic [DW-1:0]   rsp_data,
    output logic            rsp_last,
    output logic [1:0]      rsp_status,
    output logic [AW-1:0]   wb_adr_o,
    output logic [DW-1:0]   wb_dat_o,
    output logic [DW/8-1:0] wb_sel_o,
    output logic            wb_we_o,
    output logic            wb_cyc_o,
    output logic            wb_stb_o,
    output logic [2:0]      wb_cti_o,
    output logic [1:0]      wb_bte_o,
    input  logic [DW-1:0]   wb_dat_i,
    input  logic            wb_ack_i,
    input  logic            wb_err_i,
    input  logic            wb_rty_i
);
    localparam int SW = DW / 8;
    localparam int FW = LW + 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int RW = $clog2(MAXRTY + 1);

    localparam logic [1:0] ST_OK  = 2'b00;
    localparam logic [1:0] ST_ERR = 2'b01;
    localparam logic [1:0] ST_TMO = 2'b10;
    localparam logic [1:0] ST_RTY = 2'b11;

    typedef enum logic [1:0] {IDLE, BUS, BACKOFF, DONE} state_t;

    state_t        state_q, state_d;
    logic          we_q, we_d;
    logic [AW-1:0] adr_q, adr_d;
    logic [LW-1:0] len_q, len_d;
    logic [LW-1:0] beat_q, beat_d;
    logic [FW-1:0] fetched_q, fetched_d;
    logic          wvld_q, wvld_d;
    logic [DW-1:0] wdat_q, wdat_d;
    logic [SW-1:0] wsel_q, wsel_d;
    logic [RW-1:0] rty_q, rty_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic          rsp_last_q, rsp_last_d;
    logic [DW-1:0] rsp_data_q, rsp_data_d;
    logic [1:0]    rsp_status_q, rsp_status_d;

    logic cyc, stb, last_beat;
    logic term_err, term_rty, term_ack, wdat_fire;

    // Writes only strobe once a beat sits in the holding register.
    assign cyc       = (state_q == BUS);
    assign stb       = cyc && (!we_q || wvld_q);
    assign last_beat = (beat_q == len_q);

    assign term_err = stb && wb_err_i;
    assign term_rty = stb && !wb_err_i && wb_rty_i;
    assign term_ack = stb && !wb_err_i && !wb_rty_i && wb_ack_i;

    assign cmd_ready  = (state_q == IDLE);
    assign wdat_ready = cyc && we_q && (fetched_q <= {1'b0, len_q}) && (!stb || term_ack);
    assign wdat_fire  = wdat_valid && wdat_ready;

    always_comb begin
        state_d      = state_q;
        we_d         = we_q;
        adr_d        = adr_q;
        len_d        = len_q;
        beat_d       = beat_q;
        fetched_d    = fetched_q;
        wvld_d       = wvld_q;
        wdat_d       = wdat_q;
        wsel_d       = wsel_q;
        rty_d        = rty_q;
        tmo_d        = tmo_q;
        rsp_valid_d  = 1'b0;
        rsp_last_d   = 1'b0;
        rsp_data_d   = '0;
        rsp_status_d = ST_OK;

        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    we_d      = cmd_we;
                    adr_d     = cmd_adr;
                    len_d     = cmd_len;
                    beat_d    = '0;
                    fetched_d = '0;
                    wvld_d    = 1'b0;
                    rty_d     = '0;
                    tmo_d     = '0;
                    state_d   = BUS;
                end
            end
            BUS: begin
                if (wdat_fire) begin
                    wdat_d    = wdat;
                    wsel_d    = wsel;
                    wvld_d    = 1'b1;
                    fetched_d = fetched_q + FW'(1);
                end
                if (term_err) begin
                    wvld_d       = 1'b0;
                    state_d      = DONE;
                    rsp_valid_d  = 1'b1;
                    rsp_last_d   = 1'b1;
                    rsp_status_d = ST_ERR;
                end else if (term_rty) begin
                    tmo_d = '0;
                    if (rty_q < RW'(MAXRTY)) begin
                        rty_d   = rty_q + RW'(1);
                        state_d = BACKOFF;
                    end else begin
                        wvld_d       = 1'b0;
                        state_d      = DONE;
                        rsp_valid_d  = 1'b1;
                        rsp_last_d   = 1'b1;
                        rsp_status_d = ST_RTY;
                    end
                end else if (term_ack) begin
                    rty_d  = '0;
                    tmo_d  = '0;
                    adr_d  = adr_q + AW'(SW);
                    beat_d = beat_q + LW'(1);
                    wvld_d = wdat_fire;
                    if (!we_q) begin
                        rsp_valid_d = 1'b1;
                        rsp_data_d  = wb_dat_i;
                        rsp_last_d  = last_beat;
                    end
                    if (last_beat) begin
                        state_d = DONE;
                        if (we_q) begin
                            rsp_valid_d = 1'b1;
                            rsp_last_d  = 1'b1;
                        end
                    end
                end else if (stb) begin
                    if (tmo_q == TW'(TIMEOUT - 1)) begin
                        wvld_d       = 1'b0;
                        state_d      = DONE;
                        rsp_valid_d  = 1'b1;
                        rsp_last_d   = 1'b1;
                        rsp_status_d = ST_TMO;
                    end else begin
                        tmo_d = tmo_q + TW'(1);
                    end
                end
            end
            BACKOFF: state_d = BUS;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk or negedge wb_rst) begin
        if (!wb_rst) begin
            state_q      <= IDLE;
            we_q         <= 1'b0;
            adr_q        <= '0;
            len_q        <= '0;
            beat_q       <= '0;
            fetched_q    <= '0;
            wvld_q       <= 1'b0;
            wdat_q       <= '0;
            wsel_q       <= '0;
            rty_q        <= '0;
            tmo_q        <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_last_q   <= 1'b0;
            rsp_data_q   <= '0;
            rsp_status_q <= ST_OK;
        end else begin
            state_q      <= state_d;
            we_q         <= we_d;
            adr_q        <= adr_d;
            len_q        <= len_d;
            beat_q       <= beat_d;
            fetched_q    <= fetched_d;
            wvld_q       <= wvld_d;
            wdat_q       <= wdat_d;
            wsel_q       <= wsel_d;
            rty_q        <= rty_d;
            tmo_q        <= tmo_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_last_q   <= rsp_last_d;
            rsp_data_q   <= rsp_data_d;
            rsp_status_q <= rsp_status_d;
        end
    end

    // cti is derived from the beat index, so it holds through write wait states.
    always_comb begin
        wb_cti_o = 3'b000;
        if (cyc && (len_q != '0)) begin
            wb_cti_o = last_beat ? 3'b111 : 3'b010;
        end
    end

    assign wb_adr_o   = adr_q;
    assign wb_dat_o   = wdat_q;
    assign wb_sel_o   = !cyc ? '0 : (we_q ? wsel_q : '1);
    assign wb_we_o    = we_q && cyc;
    assign wb_cyc_o   = cyc;
    assign wb_stb_o   = stb;
    assign wb_bte_o   = 2'b00;

    assign rsp_valid  = rsp_valid_q;
    assign rsp_data   = rsp_data_q;
    assign rsp_last   = rsp_last_q;
    assign rsp_status = rsp_status_q;
endmodule

// File: tb/tb_peripheral_wb_master_burst.sv
module tb_peripheral_wb_master_burst;
    logic        wb_clk;
    logic        wb_rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_we;
    logic [31:0] cmd_adr;
    logic [3:0]  cmd_len;
    logic        wdat_valid;
    logic        wdat_ready;
    logic [31:0] wdat;
    logic [3:0]  wsel;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_last;
    logic [1:0]  rsp_status;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel_o;
    logic        wb_we_o;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic [2:0]  wb_cti_o;
    logic [1:0]  wb_bte_o;
    logic [31:0] wb_dat_i;
    logic        wb_ack_i;
    logic        wb_err_i;
    logic        wb_rty_i;

    int total = 0;
    int bad   = 0;

    peripheral_wb_master_burst dut (
        .wb_clk     (wb_clk),
        .wb_rst     (wb_rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_we     (cmd_we),
        .cmd_adr    (cmd_adr),
        .cmd_len    (cmd_len),
        .wdat_valid (wdat_valid),
        .wdat_ready (wdat_ready),
        .wdat       (wdat),
        .wsel       (wsel),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .rsp_last   (rsp_last),
        .rsp_status (rsp_status),
        .wb_adr_o   (wb_adr_o),
        .wb_dat_o   (wb_dat_o),
        .wb_sel_o   (wb_sel_o),
        .wb_we_o    (wb_we_o),
        .wb_cyc_o   (wb_cyc_o),
        .wb_stb_o   (wb_stb_o),
        .wb_cti_o   (wb_cti_o),
        .wb_bte_o   (wb_bte_o),
        .wb_dat_i   (wb_dat_i),
        .wb_ack_i   (wb_ack_i),
        .wb_err_i   (wb_err_i),
        .wb_rty_i   (wb_rty_i)
    );

    initial wb_clk = 1'b0;
    always #5 wb_clk = ~wb_clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        wb_rst = 1'b0; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_len = '0;
        wdat_valid = 1'b0; wdat = '0; wsel = '0;
        wb_dat_i = '0; wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_rty_i = 1'b0;

        // reset state
        repeat (2) @(negedge wb_clk);
        chk("rst_cmd_ready", 64'(cmd_ready), 64'h1);
        chk("rst_cyc", 64'(wb_cyc_o), 64'h0);
        chk("rst_stb", 64'(wb_stb_o), 64'h0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'h0);
        chk("rst_other_outs", 64'({wb_adr_o, wb_sel_o, wb_we_o, wb_cti_o, wb_bte_o, wdat_ready}), 64'h0);
        wb_rst = 1'b1;
        @(negedge wb_clk);

        // single read, two wait states
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 32'h10; cmd_len = 4'd0;
        @(negedge wb_clk);
        cmd_valid = 1'b0;
        chk("rd1_cmd_ready", 64'(cmd_ready), 64'h0);
        chk("rd1_cti", 64'(wb_cti_o), 64'h0);
        chk("rd1_adr", 64'(wb_adr_o), 64'h10);
        chk("rd1_sel", 64'(wb_sel_o), 64'hF);
        chk("rd1_we", 64'(wb_we_o), 64'h0);
        n = 0;
        while (wb_stb_o && n < 10) begin
            n++;
            if (n == 3) begin wb_ack_i = 1'b1; wb_dat_i = 32'hDEADBEEF; end
            @(negedge wb_clk);
            wb_ack_i = 1'b0;
        end
        chk("rd1_stb_cycles", 64'(n), 64'd3);
        chk("rd1_cyc_after", 64'(wb_cyc_o), 64'h0);
        chk("rd1_rsp", 64'({rsp_valid, rsp_last, rsp_status, rsp_data}), 64'({1'b1, 1'b1, 2'b00, 32'hDEADBEEF}));
        chk("rd1_done_ready", 64'(cmd_ready), 64'h0);
        @(negedge wb_clk);
        chk("rd1_idle_ready", 64'(cmd_ready), 64'h1);
        chk("rd1_rsp_pulse", 64'(rsp_valid), 64'h0);

        // 4-beat write burst with a gap before beat 3
        cmd_valid = 1'b1; cmd_we = 1'b1; cmd_adr = 32'h100; cmd_len = 4'd3;
        @(negedge wb_clk);
        cmd_valid = 1'b0;
        chk("wr_nodata_stb", 64'(wb_stb_o), 64'h0);
        chk("wr_nodata_cyc", 64'(wb_cyc_o), 64'h1);
        wdat_valid = 1'b1; wdat = 32'd1; wsel = 4'hF;
        #1 chk("wr_rdy_first", 64'(wdat_ready), 64'h1);
        @(negedge wb_clk);
        chk("wr_b1", 64'({wb_stb_o, wb_we_o, wb_cti_o, wb_sel_o, wb_adr_o, wb_dat_o}), 64'({1'b1, 1'b1, 3'b010, 4'hF, 32'h100, 32'd1}));
        wb_ack_i = 1'b1; wdat = 32'd2;
        @(negedge wb_clk);
        chk("wr_b2", 64'({wb_stb_o, wb_cti_o, wb_adr_o, wb_dat_o}), 64'({1'b1, 3'b010, 32'h104, 32'd2}));
        wdat_valid = 1'b0;
        @(negedge wb_clk);
        wb_ack_i = 1'b0;
        chk("wr_gap1", 64'({wb_cyc_o, wb_stb_o, wb_cti_o}), 64'({1'b1, 1'b0, 3'b010}));
        @(negedge wb_clk);
        chk("wr_gap2", 64'({wb_cyc_o, wb_stb_o}), 64'({1'b1, 1'b0}));
        wdat_valid = 1'b1; wdat = 32'd3;
        @(negedge wb_clk);
        chk("wr_b3", 64'({wb_stb_o, wb_cti_o, wb_adr_o, wb_dat_o}), 64'({1'b1, 3'b010, 32'h108, 32'd3}));
        wb_ack_i = 1'b1; wdat = 32'd4;
        @(negedge wb_clk);
        chk("wr_b4", 64'({wb_stb_o, wb_cti_o, wb_adr_o, wb_dat_o}), 64'({1'b1, 3'b111, 32'h10C, 32'd4}));
        chk("wr_no_early_rsp", 64'(rsp_valid), 64'h0);
        wdat_valid = 1'b0;
        #1 chk("wr_rdy_exhausted", 64'(wdat_ready), 64'h0);
        @(negedge wb_clk);
        wb_ack_i = 1'b0;
        chk("wr_cyc_after", 64'(wb_cyc_o), 64'h0);
        chk("wr_rsp", 64'({rsp_valid, rsp_last, rsp_status, rsp_data}), 64'({1'b1, 1'b1, 2'b00, 32'h0}));
        @(negedge wb_clk);
        chk("wr_idle", 64'({cmd_ready, rsp_valid}), 64'({1'b1, 1'b0}));

        // 8-beat read, error on beat 5
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 32'h200; cmd_len = 4'd7;
        @(negedge wb_clk);
        cmd_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("rde_adr", 64'(wb_adr_o), 64'(32'h200 + 4 * i));
            chk("rde_stb_cti", 64'({wb_stb_o, wb_cti_o}), 64'({1'b1, 3'b010}));
            if (i > 0) begin
                chk("rde_rsp", 64'({rsp_valid, rsp_last, rsp_status, rsp_data}),
                    64'({1'b1, 1'b0, 2'b00, 32'hA0 + 32'(i - 1)}));
            end
            if (i < 4) begin
                wb_ack_i = 1'b1; wb_dat_i = 32'hA0 + 32'(i);
            end else begin
                wb_ack_i = 1'b0; wb_err_i = 1'b1;
            end
            @(negedge wb_clk);
        end
        wb_err_i = 1'b0;
        chk("rde_cyc_after", 64'(wb_cyc_o), 64'h0);
        chk("rde_err_rsp", 64'({rsp_valid, rsp_last, rsp_status}), 64'({1'b1, 1'b1, 2'b01}));
        @(negedge wb_clk);
        chk("rde_ready_back", 64'(cmd_ready), 64'h1);

        // single write, three retries then ack
        cmd_valid = 1'b1; cmd_we = 1'b1; cmd_adr = 32'h300; cmd_len = 4'd0;
        wdat_valid = 1'b1; wdat = 32'h55; wsel = 4'h3;
        @(negedge wb_clk);
        cmd_valid = 1'b0;
        @(negedge wb_clk);
        wdat_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("rty_beat", 64'({wb_stb_o, wb_cti_o, wb_sel_o, wb_adr_o, wb_dat_o}), 64'({1'b1, 3'b000, 4'h3, 32'h300, 32'h55}));
            wb_rty_i = 1'b1;
            @(negedge wb_clk);
            wb_rty_i = 1'b0;
            chk("rty_backoff", 64'({wb_cyc_o, wb_stb_o, rsp_valid}), 64'h0);
            @(negedge wb_clk);
        end
        chk("rty_final_beat", 64'({wb_stb_o, wb_adr_o, wb_dat_o}), 64'({1'b1, 32'h300, 32'h55}));
        wb_ack_i = 1'b1;
        @(negedge wb_clk);
        wb_ack_i = 1'b0;
        chk("rty_ok_rsp", 64'({rsp_valid, rsp_last, rsp_status}), 64'({1'b1, 1'b1, 2'b00}));
        @(negedge wb_clk);
        chk("rty_ok_ready", 64'(cmd_ready), 64'h1);

        // single write, four retries exhaust the budget
        cmd_valid = 1'b1; cmd_we = 1'b1; cmd_adr = 32'h304; cmd_len = 4'd0;
        wdat_valid = 1'b1; wdat = 32'h66; wsel = 4'hF;
        @(negedge wb_clk);
        cmd_valid = 1'b0;
        @(negedge wb_clk);
        wdat_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            wb_rty_i = 1'b1;
            @(negedge wb_clk);
            wb_rty_i = 1'b0;
            chk("rtx_backoff", 64'(wb_cyc_o), 64'h0);
            @(negedge wb_clk);
        end
        chk("rtx_reissue", 64'({wb_stb_o, wb_adr_o, wb_dat_o}), 64'({1'b1, 32'h304, 32'h66}));
        wb_rty_i = 1'b1;
        @(negedge wb_clk);
        wb_rty_i = 1'b0;
        chk("rtx_abort", 64'({wb_cyc_o, rsp_valid, rsp_last, rsp_status}), 64'({1'b0, 1'b1, 1'b1, 2'b11}));
        @(negedge wb_clk);
        chk("rtx_ready", 64'(cmd_ready), 64'h1);

        // silent slave times out
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 32'h400; cmd_len = 4'd0;
        @(negedge wb_clk);
        cmd_valid = 1'b0;
        n = 0;
        while (wb_stb_o && n < 300) begin
            n++;
            @(negedge wb_clk);
        end
        chk("tmo_stb_cycles", 64'(n), 64'd255);
        chk("tmo_rsp", 64'({wb_cyc_o, rsp_valid, rsp_last, rsp_status}), 64'({1'b0, 1'b1, 1'b1, 2'b10}));
        @(negedge wb_clk);

        // reset on beat 2 of a 4-beat read
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 32'h500; cmd_len = 4'd3;
        @(negedge wb_clk);
        cmd_valid = 1'b0;
        wb_ack_i = 1'b1; wb_dat_i = 32'h11;
        @(negedge wb_clk);
        wb_ack_i = 1'b0;
        chk("rstb_beat2", 64'({wb_stb_o, wb_adr_o, rsp_valid, rsp_data}), 64'({1'b1, 32'h504, 1'b1, 32'h11}));
        #2 wb_rst = 1'b0;
        #1 chk("rstb_drop", 64'({wb_cyc_o, wb_stb_o, rsp_valid, cmd_ready}), 64'({1'b0, 1'b0, 1'b0, 1'b1}));
        @(negedge wb_clk);
        @(negedge wb_clk);
        wb_rst = 1'b1;
        n = 0;
        repeat (6) begin
            @(negedge wb_clk);
            if (rsp_valid || wb_cyc_o) n++;
        end
        chk("rstb_spurious", 64'(n), 64'd0);
        chk("rstb_ready", 64'(cmd_ready), 64'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
